// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor front end.
package cpu_pkg;

  localparam int unsigned   OP_W         = 8;
  localparam logic [7:0]    HALT_OP_DEF  = 8'hFF;
  localparam int unsigned   LONG_BIT_DEF = 7;

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    HOLD      = 2'd2,
    HALT      = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: reads one- or two-byte instructions from a combinational
// instruction memory, presents them to decode with valid/ready, and handles
// branch redirects and the halt opcode.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [OP_W-1:0] RESET_PC = 8'h00,
  parameter logic [OP_W-1:0] HALT_OP  = HALT_OP_DEF,
  parameter int unsigned     LONG_BIT = LONG_BIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            im_read,
  output logic [OP_W-1:0] im_addr,
  input  logic [OP_W-1:0] im_data,
  output logic            instr_valid,
  input  logic            decode_ready,
  output logic [OP_W-1:0] opcode,
  output logic [OP_W-1:0] operand,
  output logic [OP_W-1:0] instr_pc,
  input  logic            branch_valid,
  input  logic [OP_W-1:0] branch_target,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic [OP_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0] opcode_q, opcode_d;
  logic [OP_W-1:0] operand_q, operand_d;
  logic [OP_W-1:0] instr_pc_q, instr_pc_d;

  // State, PC and instruction registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH_OP;
      pc_q       <= RESET_PC;
      opcode_q   <= '0;
      operand_q  <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next-state and memory-port decode; a branch outside HALT pre-empts
  // everything, including an accept in the same cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    im_read    = 1'b0;
    im_addr    = pc_q;

    if (state_q == FETCH_OP || state_q == FETCH_ARG) begin
      im_read = 1'b1;
    end

    if (branch_valid && state_q != HALT) begin
      pc_d    = branch_target;
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: begin
          opcode_d   = im_data;
          instr_pc_d = pc_q;
          pc_d       = pc_q + 8'd1;
          if (im_data[LONG_BIT]) begin
            state_d = FETCH_ARG;
          end else begin
            operand_d = '0;
            state_d   = HOLD;
          end
        end
        FETCH_ARG: begin
          operand_d = im_data;
          pc_d      = pc_q + 8'd1;
          state_d   = HOLD;
        end
        HOLD: begin
          if (decode_ready) begin
            state_d = (opcode_q == HALT_OP) ? HALT : FETCH_OP;
          end
        end
        default: begin
          state_d = HALT;
        end
      endcase
    end
  end

  assign instr_valid = (state_q == HOLD);
  assign halted      = (state_q == HALT);
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table of per-cycle vectors plus
// hand-written sequences for branch, collision, wrap-around and halt.
module tb_instr_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       im_read;
  logic [7:0] im_addr;
  logic [7:0] im_data;
  logic       instr_valid;
  logic       decode_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instr_pc;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       halted;

  logic [7:0] mem [256];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct {
    bit         ld;
    logic [7:0] wa;
    logic [7:0] wd;
    string      name;
    bit         rst;
    bit         rdy;
    bit         br;
    logic [7:0] tgt;
    bit         e_read;
    logic [7:0] e_addr;
    bit         e_valid;
    logic [7:0] e_op;
    logic [7:0] e_arg;
    logic [7:0] e_pc;
    bit         e_halt;
  } vec_t;

  vec_t tbl[$];

  instr_fetch_unit #(
    .RESET_PC (8'h00),
    .HALT_OP  (8'hFF),
    .LONG_BIT (7)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .im_read       (im_read),
    .im_addr       (im_addr),
    .im_data       (im_data),
    .instr_valid   (instr_valid),
    .decode_ready  (decode_ready),
    .opcode        (opcode),
    .operand       (operand),
    .instr_pc      (instr_pc),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .halted        (halted)
  );

  assign im_data = mem[im_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input string name, input bit rst, input bit rdy,
                              input bit br, input logic [7:0] tgt,
                              input bit e_read, input logic [7:0] e_addr,
                              input bit e_valid, input logic [7:0] e_op,
                              input logic [7:0] e_arg, input logic [7:0] e_pc,
                              input bit e_halt);
    vec_t v;
    v.ld = 1'b0; v.wa = '0; v.wd = '0;
    v.name = name; v.rst = rst; v.rdy = rdy; v.br = br; v.tgt = tgt;
    v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_op = e_op; v.e_arg = e_arg; v.e_pc = e_pc; v.e_halt = e_halt;
    return v;
  endfunction

  function automatic vec_t mk_ld(input logic [7:0] a, input logic [7:0] d);
    vec_t v;
    v = mk("load", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    v.ld = 1'b1; v.wa = a; v.wd = d;
    return v;
  endfunction

  task automatic chk(input string name, input string field,
                     input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", name, field, got, exp);
    end
  endtask

  // Drive at the falling edge, compare, then let one rising edge pass.
  task automatic apply(input vec_t v);
    if (v.ld) begin
      mem[v.wa] = v.wd;
    end else begin
      rst_n         = v.rst;
      decode_ready  = v.rdy;
      branch_valid  = v.br;
      branch_target = v.tgt;
      #1;
      chk(v.name, "im_read",     {7'd0, im_read},     {7'd0, v.e_read});
      chk(v.name, "im_addr",     im_addr,             v.e_addr);
      chk(v.name, "instr_valid", {7'd0, instr_valid}, {7'd0, v.e_valid});
      chk(v.name, "opcode",      opcode,              v.e_op);
      chk(v.name, "operand",     operand,             v.e_arg);
      chk(v.name, "instr_pc",    instr_pc,            v.e_pc);
      chk(v.name, "halted",      {7'd0, halted},      {7'd0, v.e_halt});
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; decode_ready = 1'b0; branch_valid = 1'b0; branch_target = 8'h00;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);

    // One-byte fetch stream after reset.
    tbl.push_back(mk_ld(8'h00, 8'h12));
    tbl.push_back(mk_ld(8'h01, 8'h34));
    tbl.push_back(mk("s1_reset", 0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk("s1_c0",    1, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk("s1_c1",    1, 1, 0, 8'h00, 0, 8'h01, 1, 8'h12, 8'h00, 8'h00, 0));
    tbl.push_back(mk("s1_c2",    1, 1, 0, 8'h00, 1, 8'h01, 0, 8'h12, 8'h00, 8'h00, 0));
    tbl.push_back(mk("s1_c3",    1, 0, 0, 8'h00, 0, 8'h02, 1, 8'h34, 8'h00, 8'h01, 0));
    // Two-byte fetch with a 4-cycle decode stall.
    tbl.push_back(mk_ld(8'h00, 8'h85));
    tbl.push_back(mk_ld(8'h01, 8'hAB));
    tbl.push_back(mk_ld(8'h02, 8'h01));
    tbl.push_back(mk("s2_reset", 0, 0, 0, 8'h00, 0, 8'h02, 1, 8'h34, 8'h00, 8'h01, 0));
    tbl.push_back(mk("s2_op",    1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));
    tbl.push_back(mk("s2_arg",   1, 0, 0, 8'h00, 1, 8'h01, 0, 8'h85, 8'h00, 8'h00, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk("s2_stall", 1, 0, 0, 8'h00, 0, 8'h02, 1, 8'h85, 8'hAB, 8'h00, 0));
    tbl.push_back(mk("s2_accept", 1, 1, 0, 8'h00, 0, 8'h02, 1, 8'h85, 8'hAB, 8'h00, 0));
    tbl.push_back(mk("s2_next",   1, 0, 0, 8'h00, 1, 8'h02, 0, 8'h85, 8'hAB, 8'h00, 0));
    tbl.push_back(mk("s2_hold2",  1, 0, 0, 8'h00, 0, 8'h03, 1, 8'h01, 8'h00, 8'h02, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Branch during FETCH_ARG: the 85 opcode must never be presented.
    mem[8'h40] = 8'h07;
    mem[8'h50] = 8'h23;
    apply(mk("br_reset", 0, 0, 0, 8'h00, 0, 8'h03, 1, 8'h01, 8'h00, 8'h02, 0));
    apply(mk("br_op",    1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));
    apply(mk("br_arg",   1, 0, 1, 8'h40, 1, 8'h01, 0, 8'h85, 8'h00, 8'h00, 0));
    apply(mk("br_fetch", 1, 0, 0, 8'h00, 1, 8'h40, 0, 8'h85, 8'h00, 8'h00, 0));
    // Branch and accept together in HOLD: branch wins.
    apply(mk("br_hold",  1, 1, 1, 8'h50, 0, 8'h41, 1, 8'h07, 8'h00, 8'h40, 0));
    apply(mk("col_fetch",1, 0, 0, 8'h00, 1, 8'h50, 0, 8'h07, 8'h00, 8'h40, 0));
    // Wrap-around: two-byte instruction at FF takes its operand from 00.
    mem[8'hFF] = 8'h90;
    mem[8'h00] = 8'h5C;
    apply(mk("col_hold", 1, 0, 1, 8'hFF, 0, 8'h51, 1, 8'h23, 8'h00, 8'h50, 0));
    apply(mk("wr_op",    1, 0, 0, 8'h00, 1, 8'hFF, 0, 8'h23, 8'h00, 8'h50, 0));
    apply(mk("wr_arg",   1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h90, 8'h00, 8'hFF, 0));
    apply(mk("wr_hold",  1, 1, 0, 8'h00, 0, 8'h01, 1, 8'h90, 8'h5C, 8'hFF, 0));
    apply(mk("wr_next",  1, 0, 0, 8'h00, 1, 8'h01, 0, 8'h90, 8'h5C, 8'hFF, 0));
    // Halt opcode (FF is also a two-byte opcode), branch ignored, reset exits.
    mem[8'h00] = 8'hFF;
    mem[8'h01] = 8'h00;
    rst_n = 1'b0; decode_ready = 1'b0; branch_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    apply(mk("h_op",     1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));
    apply(mk("h_arg",    1, 0, 0, 8'h00, 1, 8'h01, 0, 8'hFF, 8'h00, 8'h00, 0));
    apply(mk("h_accept", 1, 1, 0, 8'h00, 0, 8'h02, 1, 8'hFF, 8'h00, 8'h00, 0));
    apply(mk("h_halt",   1, 1, 1, 8'h40, 0, 8'h02, 0, 8'hFF, 8'h00, 8'h00, 1));
    apply(mk("h_ignbr",  1, 0, 1, 8'h40, 0, 8'h02, 0, 8'hFF, 8'h00, 8'h00, 1));
    apply(mk("h_rst",    0, 0, 1, 8'h40, 0, 8'h02, 0, 8'hFF, 8'h00, 8'h00, 1));
    apply(mk("h_after",  1, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 8'h00, 8'h00, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the 8-bit processor, sitting between the program counter logic and decode and driving the read port of the instruction memory. It reads one-byte or two-byte instructions from the 256-byte instruction memory. Each fetched instruction is presented to decode with a valid/ready handshake. The unit also handles branch redirects and a halt opcode.

## Interface
Parameters:
- RESET_PC, 8'h00, PC value loaded on reset
- HALT_OP, 8'hFF, opcode that halts fetch once accepted by decode
- LONG_BIT, 7, opcode bit index; 1 = two-byte instruction (opcode + operand)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- im_read  out  1  instruction-memory read enable
- im_addr  out  8  instruction-memory address
- im_data  in  8  instruction-memory read data; combinational (same-cycle) read
- instr_valid  out  1  opcode/operand/instr_pc hold a complete instruction
- decode_ready  in  1  decode accepts the instruction this cycle
- opcode  out  8  fetched opcode byte
- operand  out  8  operand byte; 8'h00 for one-byte instructions
- instr_pc  out  8  address of the opcode byte
- branch_valid  in  1  redirect request, 1-cycle pulse
- branch_target  in  8  redirect address
- halted  out  1  unit is in HALT

## Operation
- States: FETCH_OP, FETCH_ARG, HOLD, HALT.
- Reset (rst_n=0 at posedge):
  - pc=RESET_PC, state=FETCH_OP.
  - opcode, operand and instr_pc = 8'h00.
  - instr_valid=0, halted=0.
- FETCH_OP:
  - Outputs: im_read=1, im_addr=pc.
  - At posedge: opcode<=im_data, instr_pc<=pc, pc<=pc+1.
  - If im_data[LONG_BIT]=1: go to FETCH_ARG.
  - Otherwise: operand<=8'h00 and go to HOLD.
- FETCH_ARG:
  - Outputs: im_read=1, im_addr=pc.
  - At posedge: operand<=im_data, pc<=pc+1, go to HOLD.
- HOLD:
  - instr_valid=1. opcode, operand and instr_pc stay stable until accepted.
  - Accept = instr_valid & decode_ready.
  - On accept: go to HALT if opcode==HALT_OP, else go to FETCH_OP.
- HALT:
  - halted=1, im_read=0, instr_valid=0.
  - Only reset leaves HALT.
- im_read=0 and im_addr=pc in HOLD and HALT.
- Branch (branch_valid=1 at posedge, any state except HALT):
  - pc<=branch_target, state<=FETCH_OP, instr_valid drops next cycle.
  - Any partially fetched or held instruction is discarded.
  - Branch has priority over accept. If decode_ready=1 in the same cycle, that instruction counts as not accepted.
  - HALT ignores branch_valid.
- PC arithmetic is 8-bit modulo. 8'hFF+1 wraps to 8'h00.
  - A two-byte instruction at 8'hFF takes its operand from 8'h00.
- Reset mid-operation overrides everything, including branch_valid, and returns to the reset values above.

## Timing
- Both bytes are captured at the same posedge they are addressed. No memory wait states.
- One-byte instruction: instr_valid rises 1 cycle after entering FETCH_OP.
- Two-byte instruction: instr_valid rises 2 cycles after entering FETCH_OP.
- Back-to-back with decode_ready held at 1:
  - one-byte instructions: one instruction every 2 cycles;
  - two-byte instructions: one every 3 cycles.
- After branch: first fetch from branch_target in the cycle following the branch_valid edge. instr_valid is 0 in that cycle.
- After reset release: first fetch at RESET_PC in the first cycle with rst_n=1.
- halted rises the cycle after HALT_OP is accepted.

## Structure
- Shared package (cpu_pkg): fetch state enum (FETCH_OP, FETCH_ARG, HOLD, HALT); opcode width constant 8; HALT_OP default; LONG_BIT default.
- Single module. No sub-module needed: pc register, state register and output registers live in one always block, with combinational im_read/im_addr decode.

## Test plan
- Reset, one-byte fetch:
  - Stimulus: memory [00]=8'h12, [01]=8'h34; decode_ready=1.
  - Required: instr_valid at cycle 1 with opcode 12, operand 00, instr_pc 00; then opcode 34, instr_pc 01 at cycle 3.
- Two-byte fetch with stall:
  - Stimulus: [00]=8'h85, [01]=8'hAB; decode_ready=0 for 4 cycles.
  - Required: opcode 85, operand AB, instr_pc 00 held stable with instr_valid=1; accepted when ready=1; next fetch address 02.
- Branch during FETCH_ARG:
  - Stimulus: [00]=8'h85, branch_valid with target 8'h40 in cycle 1, [40]=8'h07.
  - Required: 85 never presented; next instruction opcode 07, instr_pc 40.
- Branch versus accept collision:
  - Stimulus: branch_valid and decode_ready both asserted in HOLD.
  - Required: held instruction discarded; fetch resumes at branch_target.
- Wrap-around:
  - Stimulus: branch to FF with [FF]=8'h90, [00]=8'h5C.
  - Required: opcode 90, operand 5C, instr_pc FF; next fetch address 01.
- Halt and reset:
  - Stimulus: [00]=8'hFF accepted.
  - Required: halted=1, im_read=0, branch_valid ignored. rst_n=0 for 1 cycle then restores pc=00, halted=0.
